// File: rtl/len_to_keep_tx_pkg.sv
// Shared widths and the keep-mask type used by the tx and rx sides of the
// message egress path, so both agree on beat width.
package len_to_keep_tx_pkg;

  localparam int D_W   = 8;
  localparam int D_LW  = $clog2(D_W) + 1;
  localparam int LEN_W = 16;

  typedef logic [D_W-1:0] keep_t;

endpackage

// File: rtl/len_to_keep_tx_cnt_to_thermo.sv
// Byte count to LSB-first thermometer mask; the inverse of the count-ones
// block on the receive side. Counts above D_W saturate to all ones.
module cnt_to_thermo
  import len_to_keep_tx_pkg::*;
#(
  parameter int CW = D_W,
  parameter int CLW = D_LW
) (
  input  logic [CLW-1:0] cnt,
  output logic [CW-1:0]  thermo
);

  always_comb begin
    thermo = '0;
    for (int i = 0; i < CW; i++) begin
      thermo[i] = (i < int'(cnt));
    end
  end

endmodule

// File: rtl/len_to_keep_tx.sv
// Splits a message byte length into D_W-byte beats, each with a thermometer
// keep mask, its byte count and a last flag. Sustains one beat per cycle.
module len_to_keep_tx
  import len_to_keep_tx_pkg::*;
#(
  parameter int PD_W   = D_W,
  parameter int PD_LW  = D_LW,
  parameter int PLEN_W = LEN_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              len_valid_i,
  input  logic [PLEN_W-1:0] len_i,
  output logic              len_ready_o,
  output logic              keep_valid_o,
  input  logic              keep_ready_i,
  output logic [PD_W-1:0]   keep_o,
  output logic [PD_LW-1:0]  cnt_o,
  output logic              last_o,
  output logic              zero_len_o
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t              state;
  logic [PLEN_W-1:0]   rem;
  logic [PLEN_W-1:0]   rem_next;
  logic [PD_LW-1:0]    cnt_next;
  logic [PD_W-1:0]     keep_next;
  logic                last_next;
  logic                accept;
  logic                load;
  logic                beat_fire;

  // A new length is taken when no beat is held or the held beat is the last one leaving now.
  assign len_ready_o = !keep_valid_o | (keep_ready_i & last_o);
  assign accept      = len_valid_i & len_ready_o;
  assign load        = accept & (len_i != '0);
  assign beat_fire   = keep_valid_o & keep_ready_i;

  // rem always holds the bytes still owed including the beat on the outputs.
  always_comb begin
    rem_next  = load ? len_i : rem - PLEN_W'(PD_W);
    cnt_next  = (rem_next >= PLEN_W'(PD_W)) ? PD_LW'(PD_W) : rem_next[PD_LW-1:0];
    last_next = (rem_next <= PLEN_W'(PD_W));
  end

  cnt_to_thermo #(
    .CW  (PD_W),
    .CLW (PD_LW)
  ) u_thermo (
    .cnt    (cnt_next),
    .thermo (keep_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      rem          <= '0;
      keep_valid_o <= 1'b0;
      keep_o       <= '0;
      cnt_o        <= '0;
      last_o       <= 1'b0;
      zero_len_o   <= 1'b0;
    end else begin
      zero_len_o <= accept & (len_i == '0);
      unique case (state)
        IDLE: begin
          if (load) begin
            state        <= SEND;
            keep_valid_o <= 1'b1;
            rem          <= rem_next;
            keep_o       <= keep_next;
            cnt_o        <= cnt_next;
            last_o       <= last_next;
          end
        end
        SEND: begin
          // A new message arriving on the last handshake chains straight in.
          if (beat_fire) begin
            if (!last_o || load) begin
              rem    <= rem_next;
              keep_o <= keep_next;
              cnt_o  <= cnt_next;
              last_o <= last_next;
            end else begin
              state        <= IDLE;
              keep_valid_o <= 1'b0;
              rem          <= '0;
              keep_o       <= '0;
              cnt_o        <= '0;
              last_o       <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FORMAL
  a_count: assert property (@(posedge clk) disable iff (reset)
    $countones(keep_o) == int'(cnt_o));
  a_thermo: assert property (@(posedge clk) disable iff (reset)
    $onehot({1'b0, keep_o} + (PD_W+1)'(1)));
  a_stall: assert property (@(posedge clk) disable iff (reset)
    (keep_valid_o && !keep_ready_i) |=>
      (keep_valid_o && $stable(keep_o) && $stable(cnt_o) && $stable(last_o)));
`endif

endmodule

// File: tb/tb_len_to_keep_tx.sv
// Random and directed stimulus for len_to_keep_tx, checked against a
// queue-of-beats reference model built from message lengths.
module tb_len_to_keep_tx;
  import len_to_keep_tx_pkg::*;

  typedef struct packed {
    keep_t           keep;
    logic [D_LW-1:0] cnt;
    logic            last;
  } beat_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             lenValid;
  logic [LEN_W-1:0] lenIn;
  logic             lenReady;
  logic             keepValid;
  logic             keepReady;
  keep_t            keepOut;
  logic [D_LW-1:0]  cntOut;
  logic             lastOut;
  logic             zeroLen;

  beat_t expQ[$];
  logic  expZero = 1'b0;
  int    vectorCount = 0;
  int    missCount = 0;

  len_to_keep_tx dut (
    .clk          (clk),
    .reset        (reset),
    .len_valid_i  (lenValid),
    .len_i        (lenIn),
    .len_ready_o  (lenReady),
    .keep_valid_o (keepValid),
    .keep_ready_i (keepReady),
    .keep_o       (keepOut),
    .cnt_o        (cntOut),
    .last_o       (lastOut),
    .zero_len_o   (zeroLen)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectorCount++;
    if (obs !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // A message of len bytes is ceil(len/D_W) beats; every beat but the last is full.
  task automatic pushMessage(input int len);
    for (int off = 0; off < len; off += D_W) begin
      int    n;
      beat_t b;
      n      = (len - off < D_W) ? len - off : D_W;
      b.keep = keep_t'((64'(1) << n) - 64'(1));
      b.cnt  = D_LW'(n);
      b.last = (off + D_W >= len);
      expQ.push_back(b);
    end
  endtask

  // Called at a falling edge: check outputs, drive inputs, advance the model one cycle.
  task automatic applyStimulus(input logic lv, input logic [LEN_W-1:0] len, input logic kr);
    logic expReady;
    logic fire;
    checkOutput("keep_valid", 32'(keepValid), 32'(expQ.size() != 0));
    if (expQ.size() != 0) begin
      checkOutput("keep", 32'(keepOut), 32'(expQ[0].keep));
      checkOutput("cnt", 32'(cntOut), 32'(expQ[0].cnt));
      checkOutput("last", 32'(lastOut), 32'(expQ[0].last));
    end
    checkOutput("zero_len", 32'(zeroLen), 32'(expZero));
    lenValid  = lv;
    lenIn     = len;
    keepReady = kr;
    #1;
    expReady = (expQ.size() == 0) || (kr && expQ[0].last);
    checkOutput("len_ready", 32'(lenReady), 32'(expReady));
    fire    = (expQ.size() != 0) && kr;
    expZero = 1'b0;
    if (fire) void'(expQ.pop_front());
    if (lv && expReady) begin
      if (len == '0) expZero = 1'b1;
      else pushMessage(int'(len));
    end
    @(negedge clk);
  endtask

  task automatic drain();
    int budget = 0;
    while (expQ.size() != 0 && budget < 10000) begin
      applyStimulus(1'b0, '0, 1'b1);
      budget++;
    end
    if (expQ.size() != 0) checkOutput("drain_timeout", 32'(expQ.size()), 32'd0);
    applyStimulus(1'b0, '0, 1'b1);
  endtask

  // Asynchronous reset must clear the outputs without waiting for a clock edge.
  task automatic doReset();
    reset    = 1'b1;
    lenValid = 1'b0;
    #1;
    checkOutput("rst_keep_valid", 32'(keepValid), 32'd0);
    checkOutput("rst_keep", 32'(keepOut), 32'd0);
    checkOutput("rst_cnt", 32'(cntOut), 32'd0);
    checkOutput("rst_last", 32'(lastOut), 32'd0);
    checkOutput("rst_zero_len", 32'(zeroLen), 32'd0);
    expQ.delete();
    expZero = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    lenValid  = 1'b0;
    lenIn     = '0;
    keepReady = 1'b1;
    @(negedge clk);
    doReset();

    applyStimulus(1'b1, 16'd3, 1'b1);
    drain();
    applyStimulus(1'b1, 16'd20, 1'b1);
    drain();
    applyStimulus(1'b1, 16'd8, 1'b1);
    applyStimulus(1'b1, 16'd1, 1'b1);
    drain();

    applyStimulus(1'b1, 16'd17, 1'b1);
    applyStimulus(1'b0, '0, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 16'd5, 1'b0);
    drain();

    applyStimulus(1'b1, 16'd0, 1'b1);
    applyStimulus(1'b0, '0, 1'b1);
    applyStimulus(1'b0, '0, 1'b1);

    applyStimulus(1'b1, 16'd64, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b1);
    doReset();
    applyStimulus(1'b1, 16'd2, 1'b1);
    drain();

    applyStimulus(1'b1, 16'd16, 1'b1);
    drain();
    applyStimulus(1'b1, 16'd65535, 1'b1);
    drain();

    for (int i = 0; i < 3000; i++) begin
      logic [LEN_W-1:0] len;
      case ($urandom_range(0, 7))
        0:       len = '0;
        1:       len = LEN_W'($urandom_range(1, 300));
        default: len = LEN_W'($urandom_range(1, 40));
      endcase
      if ($urandom_range(0, 499) == 0) doReset();
      else applyStimulus(1'($urandom_range(0, 1)), len, ($urandom_range(0, 3) != 0));
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
